// File: rtl/led_blink_seq_pkg.sv
// Shared state encoding and default timing constants for the LED blink sequencer.
package led_blink_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int CLK_HZ       = 125_000_000;
    localparam int TICK_HZ      = 40;
    localparam int DEF_TICK_DIV = CLK_HZ / TICK_HZ;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_blink_seq_tick_gen.sv
// Free-running prescaler: TICK is high for one cycle every TICK_DIV cycles.
// CLR restarts the count so a new phase always starts a full tick period.
module led_blink_seq_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (CLR || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign TICK = (r_cnt == LAST);

endmodule

// File: rtl/led_blink_seq.sv
// Plays requested blink counts on an LED; requests arriving mid-sequence are
// accumulated (saturating) and played after an inter-sequence gap.
module led_blink_seq
    import led_blink_seq_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = 8,
    parameter int OFF_TICKS = 8,
    parameter int GAP_TICKS = 24,
    parameter int CNT_W     = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [CNT_W-1:0] REQ_CNT,
    output logic             LED,
    output logic             BUSY,
    output logic             DONE
);

    localparam int PH_MAX = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
    logic [CNT_W-1:0] r_pending, w_pending_nxt;
    logic [PH_W-1:0]  r_phase, w_ph_last;
    logic             r_led, r_busy, r_done;

    logic             w_tick, w_clr, w_phase_done, w_req_ok;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_pend_sat, w_pend_eff;

    led_blink_seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (w_clr),
        .TICK (w_tick)
    );

    assign w_req_ok   = REQ && (REQ_CNT != '0);
    // Sum one bit wider than the count so overflow is visible before clipping.
    assign w_sum      = {1'b0, r_pending} + {1'b0, REQ_CNT};
    assign w_pend_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    assign w_pend_eff = REQ ? w_pend_sat : r_pending;

    always_comb begin
        w_ph_last = '0;
        case (r_state)
            ST_ON:   w_ph_last = PH_W'(ON_TICKS - 1);
            ST_OFF:  w_ph_last = PH_W'(OFF_TICKS - 1);
            ST_GAP:  w_ph_last = PH_W'(GAP_TICKS - 1);
            default: w_ph_last = '0;
        endcase
    end

    assign w_phase_done = w_tick && (r_phase == w_ph_last) && (r_state != ST_IDLE);
    assign w_clr        = (r_state == ST_IDLE) || w_phase_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_phase <= '0;
        end else if (w_clr) begin
            r_phase <= '0;
        end else if (w_tick) begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_remaining_nxt = r_remaining;
        w_pending_nxt   = (r_state != ST_IDLE) ? w_pend_eff : r_pending;

        case (r_state)
            ST_IDLE: begin
                if (w_req_ok) begin
                    w_next_state    = ST_ON;
                    w_remaining_nxt = REQ_CNT;
                end
            end
            ST_ON: begin
                if (w_phase_done) begin
                    w_next_state    = ST_OFF;
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (w_phase_done) begin
                    if (r_remaining != '0) begin
                        w_next_state = ST_ON;
                    end else if (w_pend_eff != '0) begin
                        w_next_state = ST_GAP;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (w_phase_done) begin
                    w_next_state    = ST_ON;
                    w_remaining_nxt = r_pending;
                    // A request landing on the load cycle belongs to the following sequence.
                    w_pending_nxt   = REQ ? REQ_CNT : '0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_pending   <= '0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_remaining_nxt;
            r_pending   <= w_pending_nxt;
            r_led       <= (w_next_state == ST_ON);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (r_state == ST_OFF) && (w_next_state == ST_IDLE);
        end
    end

    assign LED  = r_led;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_led_blink_seq.sv
// Scoreboard bench: stimulus queues expected output events (cycle-stamped),
// a negedge monitor pops and compares each observed LED/BUSY/DONE event.
module tb_led_blink_seq;

    localparam int CNT_W = 4;

    typedef enum int {EV_BUSY_ON, EV_LED_ON, EV_LED_OFF, EV_BUSY_OFF, EV_DONE} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } ev_s;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             REQ = 1'b0;
    logic [CNT_W-1:0] REQ_CNT = '0;
    logic             LED, BUSY, DONE;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_s sb[$];

    led_blink_seq #(
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (2),
        .GAP_TICKS (3),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .REQ_CNT (REQ_CNT),
        .LED     (LED),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_ev(input ev_t kind, input int c);
        ev_s e;
        e.kind = kind;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // n blinks, first LED rise at cycle s; one blink = 16 cycles, on for 8.
    task automatic exp_blinks(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ev(EV_LED_ON,  s + 16 * i);
            exp_ev(EV_LED_OFF, s + 16 * i + 8);
        end
    endtask

    task automatic got_ev(input ev_t kind);
        ev_s e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: actual=%s required=none (cycle %0d)", kind.name(), cyc);
        end else begin
            e = sb.pop_front();
            check($sformatf("event_kind(exp %s)", e.kind.name()), int'(kind), int'(e.kind));
            check($sformatf("event_cycle(%s)", e.kind.name()), cyc, e.cyc);
        end
    endtask

    initial begin : monitor
        logic p_led, p_busy;
        p_led  = 1'b0;
        p_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (BUSY && !p_busy) got_ev(EV_BUSY_ON);
                if (LED && !p_led)   got_ev(EV_LED_ON);
                if (!LED && p_led)   got_ev(EV_LED_OFF);
                if (!BUSY && p_busy) got_ev(EV_BUSY_OFF);
                if (DONE) begin
                    got_ev(EV_DONE);
                    check("busy_low_with_done", int'(BUSY), 0);
                end
            end
            p_led  = LED;
            p_busy = BUSY;
        end
    end

    // Advance to 1 time unit after the edge that starts cycle t.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse(input logic [CNT_W-1:0] cnt);
        REQ     = 1'b1;
        REQ_CNT = cnt;
        @(posedge CLK);
        #1;
        REQ     = 1'b0;
        REQ_CNT = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({tag, "_events_left"}, sb.size(), 0);
        sb.delete();
        repeat (20) @(posedge CLK);
        #1;
    endtask

    int b;

    initial begin
        // Reset held: outputs stay idle regardless of REQ.
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            REQ     = i[0];
            REQ_CNT = 4'd3;
            check("rst_led",  int'(LED),  0);
            check("rst_busy", int'(BUSY), 0);
            check("rst_done", int'(DONE), 0);
        end
        REQ     = 1'b0;
        REQ_CNT = '0;
        RST     = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("post_rst_led",  int'(LED),  0);
        check("post_rst_busy", int'(BUSY), 0);

        // Single 3-blink sequence, then a request on the DONE cycle.
        b = cyc;
        exp_ev(EV_BUSY_ON, b + 1);
        exp_blinks(b + 1, 3);
        exp_ev(EV_BUSY_OFF, b + 49);
        exp_ev(EV_DONE,     b + 49);
        exp_ev(EV_BUSY_ON,  b + 50);
        exp_blinks(b + 50, 1);
        exp_ev(EV_BUSY_OFF, b + 66);
        exp_ev(EV_DONE,     b + 66);
        pulse(4'd3);
        goto(b + 49);
        pulse(4'd1);
        drain("single");

        // Queued request during the first sequence.
        b = cyc;
        exp_ev(EV_BUSY_ON, b + 1);
        exp_blinks(b + 1, 1);
        exp_blinks(b + 29, 2);
        exp_ev(EV_BUSY_OFF, b + 61);
        exp_ev(EV_DONE,     b + 61);
        pulse(4'd1);
        goto(b + 5);
        pulse(4'd2);
        drain("queued");

        // Zero-count request in idle does nothing.
        pulse(4'd0);
        drain("zero_idle");

        // Saturation: 9 + 9 clips to 15; zero-count request while busy is ignored.
        b = cyc;
        exp_ev(EV_BUSY_ON, b + 1);
        exp_blinks(b + 1, 1);
        exp_blinks(b + 29, 15);
        exp_ev(EV_BUSY_OFF, b + 269);
        exp_ev(EV_DONE,     b + 269);
        pulse(4'd1);
        goto(b + 3);
        pulse(4'd9);
        goto(b + 5);
        pulse(4'd9);
        goto(b + 7);
        pulse(4'd0);
        drain("saturate");

        // Request on the cycle the last OFF phase ends goes to GAP, not IDLE.
        b = cyc;
        exp_ev(EV_BUSY_ON, b + 1);
        exp_blinks(b + 1, 1);
        exp_blinks(b + 29, 2);
        exp_ev(EV_BUSY_OFF, b + 61);
        exp_ev(EV_DONE,     b + 61);
        pulse(4'd1);
        goto(b + 16);
        pulse(4'd2);
        drain("boundary");

        // Asynchronous reset in the middle of ON.
        b = cyc;
        exp_ev(EV_BUSY_ON, b + 1);
        exp_ev(EV_LED_ON,  b + 1);
        pulse(4'd3);
        goto(b + 4);
        #2;
        check("led_before_abort", int'(LED), 1);
        sb.delete();
        RST = 1'b0;
        #1;
        check("abort_led",  int'(LED),  0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        b = cyc;
        exp_ev(EV_BUSY_ON, b + 1);
        exp_blinks(b + 1, 1);
        exp_ev(EV_BUSY_OFF, b + 17);
        exp_ev(EV_DONE,     b + 17);
        pulse(4'd1);
        drain("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_blink_seq.md
Name: led_blink_seq

Overview:
- Output-side counterpart to the push-button input conditioning.
- Accepts one-cycle event requests, each carrying a blink count, from control logic (typically driven by debounced button pulses).
- Drives an LED with a human-visible blink sequence of exactly that many blinks, using timing derived from a prescaled tick.
- Requests arriving while a sequence is running are accumulated and played after an inter-sequence gap.

Parameters:
- TICK_DIV, 3125000, CLK cycles per tick (125 MHz / 40 Hz); must be >= 2.
- ON_TICKS, 8, ticks the LED stays on per blink; must be >= 1.
- OFF_TICKS, 8, ticks the LED stays off after each blink; must be >= 1.
- GAP_TICKS, 24, extra off ticks between back-to-back sequences; must be >= 1.
- CNT_W, 4, width of the blink count; pending saturates at 2^CNT_W-1.

Ports:
- CLK  in  1  system clock, the only clock.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  1  one-cycle request strobe.
- REQ_CNT  in  CNT_W  blink count sampled when REQ=1; 0 means ignore.
- LED  out  1  LED drive, 1 = on.
- BUSY  out  1  high while a sequence or gap is in progress.
- DONE  out  1  one-cycle pulse when returning to idle.

Behaviour:
- Reset (RST=0, asynchronous):
  - LED=0, BUSY=0, DONE=0.
  - State IDLE; remaining=0, pending=0; prescaler and phase counter cleared.
  - Mid-sequence reset aborts immediately with no DONE.
- Prescaler:
  - tick=1 every TICK_DIV cycles.
  - Synchronously cleared on every phase entry, so each phase lasts exactly N*TICK_DIV cycles.
- Phase counter counts ticks within the current phase.
- States:
  - IDLE: LED=0, BUSY=0. On REQ with REQ_CNT!=0: remaining=REQ_CNT, go to ON next cycle. REQ with REQ_CNT=0 does nothing.
  - ON: LED=1, BUSY=1. After ON_TICKS ticks go to OFF and decrement remaining.
  - OFF: LED=0, BUSY=1. After OFF_TICKS ticks:
    - remaining!=0: go to ON.
    - remaining=0 and effective pending!=0: go to GAP.
    - otherwise: go to IDLE.
  - GAP: LED=0, BUSY=1. After GAP_TICKS ticks: remaining=pending, pending=0, go to ON.
- Latency:
  - REQ in cycle t (IDLE) gives LED=1 from t+1.
  - Each blink occupies (ON_TICKS+OFF_TICKS)*TICK_DIV cycles.
- Request while not IDLE:
  - pending = min(pending + REQ_CNT, 2^CNT_W-1).
  - Compute the sum in CNT_W+1 bits, then clip.
- Simultaneous events:
  - REQ in the same cycle as the last OFF phase ends counts as pending, so the block goes to GAP, not IDLE.
  - REQ in the same cycle as GAP ends is added to pending after the load, so it is played after the following sequence.
- DONE:
  - Asserted for the single cycle in which the state is first IDLE after OFF.
  - BUSY=0 in that same cycle.
  - A new REQ in that cycle is accepted as from IDLE.
- All outputs are registered; no combinational path from REQ to LED.

Decomposition:
- Shared package:
  - state enum (IDLE, ON, OFF, GAP), 2-bit encoding.
  - default tick constants (CLK_HZ=125000000, TICK_HZ=40, derived TICK_DIV).
- Sub-module tick_gen:
  - Prescaler with parameter TICK_DIV.
  - Inputs CLK, RST, CLR; output TICK.
  - Reusable by the input-side debounce logic.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=3 unless noted):
- Reset values: hold RST=0, toggle REQ -> LED=0, BUSY=0, DONE=0 throughout; release RST -> still idle.
- Single sequence: REQ=1, REQ_CNT=3 at cycle 0 ->
  - LED=1 cycles 1-8, 17-24, 33-40; LED=0 cycles 9-16, 25-32, 41-48.
  - BUSY=1 cycles 1-48.
  - Cycle 49: DONE=1, BUSY=0.
- Queued request: REQ_CNT=1 at cycle 0, REQ_CNT=2 at cycle 5 ->
  - blink cycles 1-8, off 9-16.
  - GAP 17-28.
  - LED=1 cycles 29-36 and 45-52.
  - DONE cycle 61, exactly one DONE overall.
- Saturation and zero: CNT_W=4, start REQ_CNT=1, then REQ_CNT=9 twice while busy, plus REQ_CNT=0 ->
  - second sequence has exactly 15 blinks.
  - REQ_CNT=0 has no effect, including in IDLE.
- Boundary REQ: REQ_CNT=2 issued in the cycle the last OFF phase ends (cycle 16 of a 1-blink run) ->
  - no DONE at 17.
  - GAP then 2 blinks.
  - DONE after the final OFF.
- Async reset mid-ON: assert RST=0 asynchronously during ON -> LED falls without a CLK edge; no DONE; REQ after release restarts cleanly with full-length phases.
